usb_rx_crc16_chk: RTL
=====================

USB_RX_CRC16_CHK -- requirements
Module: usb_rx_crc16_chk

Interface
REQ-001 Parameter DEPTH, default 4: output FIFO entries; power of 2, >=2.
REQ-002 Parameter STRIP_CRC, default 1: 1 = two trailing CRC bytes removed from downstream stream; 0 = forwarded.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rx_data_on  in  1  DATA phase enable from link control.
REQ-006 rx_sop / rx_eop  in  1 / 1  first / last byte of DATA packet, qualified by rx_valid.
REQ-007 rx_valid  in  1, rx_ready  out  1, rx_data  in  8: upstream byte handshake.
REQ-008 rx_lt_sop / rx_lt_eop / rx_lt_valid  out  1 each, rx_lt_ready  in  1, rx_lt_data  out  8: transfer-layer handshake.
REQ-009 rx_sop_en  out  1  combinational: rx_data_on & rx_valid & rx_ready & rx_sop.
REQ-010 rx_lt_eop_en  out  1  combinational: rx_lt_valid & rx_lt_ready & rx_lt_eop.
REQ-011 crc16_err  out  1  result of last completed packet; crc_done  out  1  one-cycle pulse per completed packet; zlp  out  1  pulse with crc_done when payload length is 0.

Function
REQ-012 Accept = rx_valid & rx_ready; rx_ready = FIFO not full; bytes accepted while rx_data_on=0 are dropped, no state change.
REQ-013 CRC is CRC-16/USB: poly 0x8005, init 0xFFFF, LSB-first (reflected in/out), xorout 0xFFFF; received CRC low byte first.
REQ-014 Running CRC seeded 0xFFFF on accepted sop byte; updated over payload bytes only; comparison in the same cycle the eop byte is accepted.
REQ-015 Delay FSM (STRIP_CRC=1), states IDLE, H1 (one byte held), H2 (two bytes held): IDLE-sop->H1; H1-byte->H2; H2-byte->H2 pushing oldest held byte to FIFO; any eop->IDLE.
REQ-016 On eop in H2: byte pushed in that cycle (if any) carries eop=1; the two bytes held/arriving are CRC and are not pushed.
REQ-017 Payload length 0 (sop byte, eop byte = CRC only): nothing pushed, zlp=1, CRC compared against 0x0000.
REQ-018 Packet of one byte (sop & eop same beat): crc16_err=1, nothing pushed, crc_done=1.
REQ-019 First pushed payload byte carries sop=1; sop with length 0 is not emitted.
REQ-020 STRIP_CRC=0: every accepted byte pushed same cycle with its own sop/eop; CRC check identical.
REQ-021 Sop accepted while not IDLE: held bytes discarded, CRC reseeded, FSM->H1; no crc_done for aborted packet.
REQ-022 FIFO: push/pop same cycle when full allowed only as pop then push; rx_lt_valid = FIFO not empty; no combinational path rx_lt_ready->rx_lt_valid.
REQ-023 Latency: byte pushed at edge N visible on rx_lt_* after edge N (first-word fall-through from registers).
REQ-024 crc16_err and crc_done registered one cycle after eop accept; crc16_err holds until next crc_done.

Reset
REQ-025 On rst_n low: FSM IDLE, FIFO empty, CRC 0xFFFF, rx_lt_valid/sop/eop 0, rx_lt_data 0x00, crc16_err 0, crc_done 0, zlp 0; rx_ready 1.
REQ-026 Reset mid-packet discards all held and queued bytes; no crc_done emitted.

Configuration
REQ-027 Macro CRC16_ERR_CNT_EN defined: adds input cnt_clr (1) and output err_cnt (8), saturating at 0xFF, +1 per crc_done with error, cleared by cnt_clr (clear wins over increment), reset 0.
REQ-028 Macro undefined: cnt_clr and err_cnt ports absent; all other behaviour identical.

Verification
REQ-029 Payload 31..39, CRC C8 B4, rx_lt_ready=1 -> 9 bytes out, sop on 0x31, eop on 0x39, crc16_err=0, crc_done one pulse.
REQ-030 Same packet with CRC C8 B5 -> same 9 bytes out, crc16_err=1; err_cnt=1 when CRC16_ERR_CNT_EN.
REQ-031 Packet 00 00 only -> no output bytes, zlp=1, crc16_err=0.
REQ-032 rx_lt_ready=0 with DEPTH=4, 12-byte payload -> rx_ready drops after 4 pushes, no byte lost or duplicated after release.
REQ-033 Second sop after 3 bytes, then valid 31..39 C8 B4 packet -> crc16_err=0, single crc_done.
REQ-034 rst_n asserted mid-payload -> all outputs at reset values next cycle, subsequent good packet passes.

Source files
------------

// File: rtl/usb_rx_crc16_chk.sv
// usb_rx_crc16_chk: USB DATA-packet receive CRC-16 checker.
// - Runs CRC-16/USB over the payload and checks it against the two trailing
//   CRC bytes.
// - With STRIP_CRC=1, a two-byte delay line holds the CRC bytes back so they
//   never reach the transfer layer.
// - Payload bytes leave through a DEPTH-entry first-word-fall-through FIFO.
// - Optional feature: define CRC16_ERR_CNT_EN to add cnt_clr/err_cnt, a
//   saturating counter of packets that failed the CRC check.
module usb_rx_crc16_chk #(
  parameter int DEPTH     = 4,
  parameter int STRIP_CRC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_data_on,
  input  logic       rx_sop,
  input  logic       rx_eop,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       rx_lt_sop,
  output logic       rx_lt_eop,
  output logic       rx_lt_valid,
  input  logic       rx_lt_ready,
  output logic [7:0] rx_lt_data,
  output logic       rx_sop_en,
  output logic       rx_lt_eop_en,
  output logic       crc16_err,
  output logic       crc_done,
  output logic       zlp
`ifdef CRC16_ERR_CNT_EN
  ,
  input  logic       cnt_clr,
  output logic [7:0] err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, H1, H2} state_t;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } beat_t;

  // Reflected CRC-16 (poly 0x8005 -> 0xA001), one byte, LSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  hold0_q, hold0_d;   // oldest held byte
  logic [7:0]  hold1_q, hold1_d;   // newest held byte
  logic [15:0] crc_q, crc_d;
  logic        first_q, first_d;   // next pushed byte is the packet's first
  logic        crc16_err_q, err_d;
  logic        crc_done_q, done_d;
  logic        zlp_q, zlp_d;

  beat_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q;

  logic        acc_on, pop, push;
  logic        s_push, s_eop;
  beat_t       push_beat, head;
  logic [15:0] crc_upd;

  assign rx_ready     = (cnt_q != FULL_CNT);
  assign acc_on       = rx_valid & rx_ready & rx_data_on;
  assign rx_sop_en    = rx_data_on & rx_valid & rx_ready & rx_sop;
  assign rx_lt_valid  = (cnt_q != '0);
  assign pop          = rx_lt_valid & rx_lt_ready;
  assign rx_lt_eop_en = rx_lt_valid & rx_lt_ready & rx_lt_eop;
  assign crc_upd      = crc_byte(crc_q, hold0_q);

  assign head        = mem_q[rd_q];
  assign rx_lt_data  = rx_lt_valid ? head.data : 8'h00;
  assign rx_lt_sop   = rx_lt_valid & head.sop;
  assign rx_lt_eop   = rx_lt_valid & head.eop;

  assign crc16_err = crc16_err_q;
  assign crc_done  = crc_done_q;
  assign zlp       = zlp_q;

  // Delay-line FSM: CRC runs over the byte leaving the hold pair, so the
  // last two bytes of a packet (the CRC) are never folded in.
  always_comb begin
    state_d = state_q;
    hold0_d = hold0_q;
    hold1_d = hold1_q;
    crc_d   = crc_q;
    first_d = first_q;
    err_d   = crc16_err_q;
    done_d  = 1'b0;
    zlp_d   = 1'b0;
    s_push  = 1'b0;
    s_eop   = 1'b0;
    if (acc_on) begin
      if (rx_sop) begin
        // A new sop always restarts; any held bytes are dropped.
        crc_d   = 16'hFFFF;
        first_d = 1'b1;
        hold0_d = rx_data;
        if (rx_eop) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = H1;
        end
      end else begin
        unique case (state_q)
          IDLE: ;
          H1: begin
            if (rx_eop) begin
              state_d = IDLE;
              done_d  = 1'b1;
              zlp_d   = 1'b1;
              err_d   = ({rx_data, hold0_q} != ~crc_q);
            end else begin
              hold1_d = rx_data;
              state_d = H2;
            end
          end
          H2: begin
            s_push  = 1'b1;
            first_d = 1'b0;
            crc_d   = crc_upd;
            hold0_d = hold1_q;
            hold1_d = rx_data;
            if (rx_eop) begin
              s_eop   = 1'b1;
              state_d = IDLE;
              done_d  = 1'b1;
              err_d   = ({rx_data, hold1_q} != ~crc_upd);
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Select what enters the FIFO: delayed payload or raw accepted bytes.
  always_comb begin
    if (STRIP_CRC != 0) begin
      push      = s_push;
      push_beat = '{sop: first_q, eop: s_eop, data: hold0_q};
    end else begin
      push      = acc_on;
      push_beat = '{sop: rx_sop, eop: rx_eop, data: rx_data};
    end
  end

  // FSM, hold bytes, running CRC and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold0_q     <= 8'h00;
      hold1_q     <= 8'h00;
      crc_q       <= 16'hFFFF;
      first_q     <= 1'b0;
      crc16_err_q <= 1'b0;
      crc_done_q  <= 1'b0;
      zlp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
      crc_q       <= crc_d;
      first_q     <= first_d;
      crc16_err_q <= err_d;
      crc_done_q  <= done_d;
      zlp_q       <= zlp_d;
    end
  end

  // Output FIFO; a pop and push in the same cycle behave as pop then push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_beat;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef CRC16_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  assign err_cnt = err_cnt_q;

  // Saturating count of failed packets; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          err_cnt_q <= 8'h00;
    else if (cnt_clr)                                    err_cnt_q <= 8'h00;
    else if (crc_done_q && crc16_err_q && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 8'h01;
  end
`endif

endmodule
